// File: rtl/wz_pkg.sv
// Shared definitions for the working-zone encoder/decoder pair: FSM states,
// default geometry, RAM map and code-byte field positions.
package wz_pkg;

   typedef enum logic [5:0] {
      S_WAIT   = 6'b000001,
      S_READ   = 6'b000010,
      S_LAST   = 6'b000100,
      S_DECODE = 6'b001000,
      S_WRITE  = 6'b010000,
      S_DONE   = 6'b100000
   } wz_state_t;

   localparam int         N_WZ_DEF      = 8;
   localparam int         WZ_DIM_DEF    = 4;
   localparam logic [7:0] BASE_ADDR_DEF = 8'd0;
   localparam logic [7:0] CODE_ADDR_DEF = 8'd9;
   localparam logic [7:0] OUT_ADDR_DEF  = 8'd10;

   // code byte layout: {flag, zone[2:0], one-hot offset[3:0]}
   localparam int FLAG_BIT = 7;
   localparam int ZONE_HI  = 6;
   localparam int ZONE_LO  = 4;
   localparam int OFS_LO   = 0;

endpackage

// File: rtl/working_zone_decoder_if.sv
// RAM bus plus start/done handshake between the decoder (master) and the
// shared RAM / sequencer side (slave).
interface working_zone_decoder_if;
   logic        i_start;
   logic [7:0]  i_data;
   logic [15:0] o_address;
   logic        o_en;
   logic        o_we;
   logic [7:0]  o_data;
   logic        o_done;
   logic        o_err;

   modport master (
      input  i_start, i_data,
      output o_address, o_en, o_we, o_data, o_done, o_err
   );

   modport slave (
      output i_start, i_data,
      input  o_address, o_en, o_we, o_data, o_done, o_err
   );
endinterface

// File: rtl/wz_code_decode.sv
// Combinational code-byte decode: pass-through or base[zone] + one-hot offset.
// Illegal-code detection only when WZ_ERR_CHECK_EN is defined.
module wz_code_decode
   import wz_pkg::*;
#(
   parameter int N_WZ   = N_WZ_DEF,
   parameter int WZ_DIM = WZ_DIM_DEF
) (
   input  logic [7:0]            code,
   input  logic [N_WZ-1:0][7:0]  bases,
   output logic [7:0]            result,
   output logic                  illegal
);

   logic [ZONE_HI-ZONE_LO:0] zone;
   logic [7:0]               offset;

   assign zone = code[ZONE_HI:ZONE_LO];

   // scanning downwards leaves the lowest set bit; all-zero yields offset 0
   always_comb begin
      offset = '0;
      for (int i = WZ_DIM - 1; i >= 0; i--) begin
         if (code[OFS_LO + i]) begin
            offset = 8'(i);
         end
      end
   end

`ifdef WZ_ERR_CHECK_EN
   logic [3:0] ones;
   always_comb begin
      ones = '0;
      for (int i = 0; i < WZ_DIM; i++) begin
         if (code[OFS_LO + i]) begin
            ones = ones + 4'd1;
         end
      end
      illegal = code[FLAG_BIT] && (ones != 4'd1);
   end
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      result = code;
      if (code[FLAG_BIT] && !illegal) begin
         result = bases[zone] + offset;
      end
   end

endmodule

// File: rtl/working_zone_decoder.sv
// Working-zone decoder: reads N_WZ bases + code byte, writes decoded address.
// o_done 13 edges after start; o_err driven only with WZ_ERR_CHECK_EN defined.
module working_zone_decoder
   import wz_pkg::*;
#(
   parameter int         N_WZ      = N_WZ_DEF,
   parameter int         WZ_DIM    = WZ_DIM_DEF,
   parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter logic [7:0] CODE_ADDR = CODE_ADDR_DEF,
   parameter logic [7:0] OUT_ADDR  = OUT_ADDR_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   working_zone_decoder_if.master bus
);

   localparam int CW = $clog2(N_WZ + 1);
   localparam int IW = $clog2(N_WZ);

   wz_state_t            state;
   logic [CW-1:0]        rd_cnt;
   logic [CW-1:0]        tag_idx;
   logic                 tag_vld;
   logic [N_WZ-1:0][7:0] bases;
   logic [7:0]           code;
   logic [7:0]           addr_q;
   logic [7:0]           dat_q;
   logic                 en_q;
   logic                 we_q;
   logic                 done_q;
   logic                 err_q;
   logic [7:0]           result;
   logic                 illegal;

   wz_code_decode #(.N_WZ(N_WZ), .WZ_DIM(WZ_DIM)) u_decode (
      .code    (code),
      .bases   (bases),
      .result  (result),
      .illegal (illegal)
   );

   assign bus.o_address = {8'h00, addr_q};
   assign bus.o_en      = en_q;
   assign bus.o_we      = we_q;
   assign bus.o_data    = dat_q;
   assign bus.o_done    = done_q;
   assign bus.o_err     = err_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= S_WAIT;
         rd_cnt  <= '0;
         tag_idx <= '0;
         tag_vld <= 1'b0;
         bases   <= '0;
         code    <= '0;
         addr_q  <= '0;
         dat_q   <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // RAM data lags its address by one cycle, so the read slot is tagged
         tag_vld <= en_q & ~we_q;
         tag_idx <= rd_cnt;
         if (tag_vld) begin
            if (tag_idx == CW'(N_WZ)) begin
               code <= bus.i_data;
            end else begin
               bases[tag_idx[IW-1:0]] <= bus.i_data;
            end
         end

         unique case (state)
            S_WAIT: begin
               if (bus.i_start) begin
                  state  <= S_READ;
                  rd_cnt <= '0;
                  en_q   <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= BASE_ADDR;
               end
            end
            S_READ: begin
               if (rd_cnt == CW'(N_WZ)) begin
                  state <= S_LAST;
                  en_q  <= 1'b0;
               end else begin
                  rd_cnt <= rd_cnt + CW'(1);
                  addr_q <= (rd_cnt == CW'(N_WZ - 1)) ? CODE_ADDR
                                                      : BASE_ADDR + 8'(rd_cnt) + 8'd1;
               end
            end
            S_LAST: begin
               state <= S_DECODE;
            end
            S_DECODE: begin
               state  <= S_WRITE;
               dat_q  <= result;
               err_q  <= illegal;
               en_q   <= 1'b1;
               we_q   <= 1'b1;
               addr_q <= OUT_ADDR;
            end
            S_WRITE: begin
               state  <= S_DONE;
               en_q   <= 1'b0;
               we_q   <= 1'b0;
               done_q <= 1'b1;
            end
            S_DONE: begin
               if (!bus.i_start) begin
                  state  <= S_WAIT;
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
               end
            end
            default: begin
               state <= S_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_working_zone_decoder.sv
// Randomised scoreboard bench for working_zone_decoder against a behavioural RAM
// and a zone/offset reference model.
module tb_working_zone_decoder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   working_zone_decoder_if bus();

   working_zone_decoder dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // behavioural single-port RAM, one-cycle read latency
   logic [7:0] mem [256];
   logic [7:0] rdata;
   always @(posedge clk) begin
      if (bus.o_en) begin
         if (bus.o_we) mem[bus.o_address[7:0]] = bus.o_data;
         else          rdata <= mem[bus.o_address[7:0]];
      end
   end
   assign bus.i_data = rdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   logic done_prev = 1'b0;
   logic [7:0] base_m [8];

   int   rd_q  [$];
   int   wr_q  [$];
   logic err_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // reference: flag clear -> pass-through, else base of zone plus lowest set offset bit
   function automatic void model(input logic [7:0] c, output int d, output logic e);
      int ofs;
      int ones;
      int zone;
      ofs  = -1;
      ones = 0;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) begin
            ones++;
            if (ofs < 0) ofs = i;
         end
      end
      if (ofs < 0) ofs = 0;
      zone = int'(c[6:4]);
      e = 1'b0;
      if (c[7] == 1'b0) d = int'(c);
      else              d = (int'(base_m[zone]) + ofs) % 256;
`ifdef WZ_ERR_CHECK_EN
      if (c[7] && ones != 1) begin
         d = int'(c);
         e = 1'b1;
      end
`endif
   endfunction

   // monitor: pops expectations whenever the DUT presents a RAM access or done
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_en && !bus.o_we) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got read at 0x%0h expected no access", bus.o_address);
            end else begin
               chk("rd_addr", int'(bus.o_address), rd_q.pop_front());
            end
         end
         if (bus.o_en && bus.o_we) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected: got write at 0x%0h expected no access", bus.o_address);
            end else begin
               chk("wr_addr", int'(bus.o_address), 10);
               chk("wr_data", int'(bus.o_data), wr_q.pop_front());
            end
         end
         if (bus.o_done && !done_prev) begin
            chk("done_latency", cyc - start_cyc + 1, 13);
            if (err_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: got done=1 expected no done");
            end else begin
               chk("err_at_done", int'(bus.o_err), int'(err_q.pop_front()));
            end
         end
      end
      done_prev = bus.o_done;
   end

   task automatic set_base(input int k, input logic [7:0] v);
      base_m[k] = v;
      mem[k]    = v;
   endtask

   task automatic expect_reads();
      for (int k = 0; k < 8; k++) rd_q.push_back(k);
      rd_q.push_back(9);
   endtask

   task automatic run_case(input logic [7:0] c, input bit hold);
      int   exp_d;
      logic exp_e;
      bit   seen;
      rd_q.delete(); wr_q.delete(); err_q.delete();
      mem[9]  = c;
      mem[10] = 8'hEE;
      model(c, exp_d, exp_e);
      expect_reads();
      wr_q.push_back(exp_d);
      err_q.push_back(exp_e);
      @(negedge clk);
      start_cyc   = cyc + 1;
      bus.i_start = 1'b1;
      if (!hold) begin
         @(negedge clk);
         bus.i_start = 1'b0;
      end
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         seen = bus.o_done;
      end
      chk("done_seen", int'(seen), 1);
      chk("ram_out", int'(mem[10]), exp_d);
      chk("reads_all", rd_q.size(), 0);
      if (hold) begin
         for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("done_hold", int'(bus.o_done), 1);
         end
         bus.i_start = 1'b0;
      end
      @(negedge clk);
      chk("done_drop", int'(bus.o_done), 0);
      chk("err_drop", int'(bus.o_err), 0);
   endtask

   initial begin
      bit found;
      logic [7:0] c;
      rst_n       = 1'b0;
      bus.i_start = 1'b0;
      for (int k = 0; k < 256; k++) mem[k] = 8'h00;
      set_base(0, 8'd4);  set_base(1, 8'd13); set_base(2, 8'd22); set_base(3, 8'd31);
      set_base(4, 8'd37); set_base(5, 8'd45); set_base(6, 8'd77); set_base(7, 8'd91);
      repeat (3) @(negedge clk);
      chk("rst_en", int'(bus.o_en), 0);
      chk("rst_we", int'(bus.o_we), 0);
      chk("rst_addr", int'(bus.o_address), 0);
      chk("rst_data", int'(bus.o_data), 0);
      chk("rst_done", int'(bus.o_done), 0);
      chk("rst_err", int'(bus.o_err), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_en", int'(bus.o_en), 0);

      run_case(8'h2A, 1'b0);
      run_case(8'hB4, 1'b0);
      run_case(8'h83, 1'b0);
      set_base(7, 8'd254);
      run_case(8'hF8, 1'b0);

      // abort in the middle of the base reads
      rd_q.delete(); wr_q.delete(); err_q.delete();
      mem[9]  = 8'hB4;
      mem[10] = 8'hEE;
      expect_reads();
      @(negedge clk);
      start_cyc   = cyc + 1;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         if (bus.o_en && bus.o_address == 16'd5) found = 1'b1;
         else @(negedge clk);
      end
      chk("rst_k5_seen", int'(found), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_en", int'(bus.o_en), 0);
      chk("abort_addr", int'(bus.o_address), 0);
      chk("abort_data", int'(bus.o_data), 0);
      chk("abort_done", int'(bus.o_done), 0);
      rd_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_no_write", int'(mem[10]), 8'hEE);
      chk("abort_idle_done", int'(bus.o_done), 0);

      run_case(8'h2A, 1'b1);
      run_case(8'hB4, 1'b0);

      for (int n = 0; n < 16; n++) begin
         for (int k = 0; k < 8; k++) set_base(k, 8'($urandom_range(0, 255)));
         c = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            c[7]   = 1'b1;
            c[3:0] = 4'b0001 << $urandom_range(0, 3);
         end
         run_case(c, n[2]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
